l1_ext_mem_responder: RTL and testbench
=======================================

// Module: l1_ext_mem_responder
// PURPOSE
//  External-memory responder on the L1 cache's memory interface; the target side of mem_cs/mem_we/ack.
//  Holds a block-organised backing store and serves one block read or write per request.
//  Acks each request after a fixed, programmable access latency.
//  Sits between the L1 cache controller and the simulation/FPGA memory boundary.
// PARAMETERS
//  ADDR_W    32    byte-address width
//  BLOCK_W   128   block (cache line) width in bits; 16-byte blocks, addr[3:0] ignored
//  DEPTH     1024  number of blocks stored; power of 2; IDX_W = log2(DEPTH)
//  LATENCY   10    cycles from request acceptance to ack; legal range 1..255
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-low
//  mem_cs     in   1        request valid; level, held by initiator until mem_ack
//  mem_we     in   1        1 = block write, 0 = block read; sampled at acceptance
//  mem_addr   in   ADDR_W   byte address; block index = mem_addr[IDX_W+3:4]
//  mem_wdata  in   BLOCK_W  write block; sampled at acceptance
//  mem_rdata  out  BLOCK_W  read block; valid with mem_ack on reads, held until next read ack
//  mem_ack    out  1        one-cycle completion pulse, registered
//  mem_busy   out  1        high from acceptance through the ack cycle
//  mem_err    out  1        range error flag, valid with mem_ack (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, mem_ack=0, mem_busy=0, mem_err=0, mem_rdata=0, counter=0.
//    Storage array is not reset.
//  FSM states: IDLE, WAIT, ACK.
//  IDLE: mem_cs=1 at a rising edge accepts the request.
//    - Latches mem_we, block index and mem_wdata.
//    - Loads cnt=LATENCY-1 and sets mem_busy=1.
//    - Next state is ACK if LATENCY==1, else WAIT.
//  WAIT: decrements cnt each cycle; moves to ACK when cnt reaches 1.
//  ACK (one cycle): mem_ack=1.
//    - Write: latched block is written to the array at the edge that enters ACK.
//    - Read: array[index] is loaded into mem_rdata at the edge that enters ACK.
//    - Next state is always IDLE; mem_busy drops with mem_ack.
//  Latency: cs first high in cycle 0 gives mem_ack high in cycle LATENCY, exactly one cycle wide.
//  Back-to-back requests: the initiator may keep mem_cs high across ack and change mem_we/addr.
//    - The request is re-sampled in the IDLE cycle after ack, giving a 1-cycle gap.
//    - Write-back followed by allocate therefore costs 2*LATENCY+1 cycles.
//  mem_cs dropping in WAIT aborts the request.
//    - Return to IDLE with no ack and no array write.
//    - mem_rdata is unchanged.
//  mem_we/mem_addr/mem_wdata changing during WAIT are ignored; latched values are used.
//  Read-after-write to the same block returns the newly written data.
//  Reset mid-operation: immediate return to IDLE; a pending write is not committed.
//  Counter is 8 bits; no wrap, since it is reloaded only at acceptance.
// CONFIGURATION
//  MEM_RANGE_CHECK_EN defined:
//    - Acceptance checks mem_addr[ADDR_W-1:IDX_W+4] != 0.
//    - Out-of-range requests still ack after LATENCY with mem_err=1.
//    - They do no array write, and mem_rdata is forced to 0 on reads.
//    - mem_err=0 on in-range acks.
//  MEM_RANGE_CHECK_EN undefined: upper address bits are ignored (index wraps modulo DEPTH).
//    mem_err is tied to 0.
// TESTING
//  1. Reset then idle 5 cycles -> mem_ack=0, mem_busy=0, mem_rdata=0.
//  2. LATENCY=10: write addr 0x40 data 0xA5..A5, then read 0x40
//     -> ack at cycle 10 of each request, rdata=0xA5..A5.
//  3. mem_cs held high, write 0x80 then read 0x80 with mem_we flipped at ack
//     -> second ack exactly 11 cycles after first, correct data.
//  4. LATENCY=1: read 0x00 -> mem_ack in cycle 1.
//     Drop cs in cycle 3 of a LATENCY=10 write -> no ack, later read shows old data.
//  5. rst low mid-WAIT of a write to 0x100 -> outputs reset, write not committed.
//  6. MEM_RANGE_CHECK_EN, DEPTH=1024, read 0x0001_0000 -> ack with mem_err=1, rdata=0.
//     Without the macro, the same read returns block 0.

Source files
------------

// File: rtl/l1_ext_mem_responder.sv
// l1_ext_mem_responder: block-organised backing store answering L1 mem_cs/mem_we requests after LATENCY cycles.
// Define MEM_RANGE_CHECK_EN to flag accesses beyond DEPTH blocks through mem_err instead of wrapping.
module l1_ext_mem_responder #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_cs,
    input  logic               mem_we,
    input  logic [ADDR_W-1:0]  mem_addr,
    input  logic [BLOCK_W-1:0] mem_wdata,
    output logic [BLOCK_W-1:0] mem_rdata,
    output logic               mem_ack,
    output logic               mem_busy,
    output logic               mem_err
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t             state_q;
    logic [7:0]         cnt_q;
    logic               we_q;
    logic               oor_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BLOCK_W-1:0] wdata_q;
    logic [BLOCK_W-1:0] rdata_q;
    logic               ack_q;
    logic               busy_q;
    logic               err_q;
    logic [BLOCK_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]   req_idx;
    logic               req_oor;
    logic               cur_we;
    logic               cur_oor;
    logic [IDX_W-1:0]   cur_idx;
    logic [BLOCK_W-1:0] cur_wdata;
    logic               enter_ack;
    logic               unused_addr;

    assign req_idx     = mem_addr[IDX_W+3:4];
    assign unused_addr = ^{mem_addr[3:0], mem_addr[ADDR_W-1:IDX_W+4]};

`ifdef MEM_RANGE_CHECK_EN
    assign req_oor = |mem_addr[ADDR_W-1:IDX_W+4];
`else
    assign req_oor = 1'b0;
`endif

    // With LATENCY==1 the ACK edge is also the acceptance edge, so live inputs are used there.
    always_comb begin
        cur_we    = we_q;
        cur_oor   = oor_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        enter_ack = 1'b0;
        if (state_q == IDLE) begin
            cur_we    = mem_we;
            cur_oor   = req_oor;
            cur_idx   = req_idx;
            cur_wdata = mem_wdata;
            enter_ack = rst && mem_cs && (LATENCY == 1);
        end else if (state_q == WAIT) begin
            enter_ack = rst && mem_cs && (cnt_q == 8'd1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_cs) begin
                        we_q    <= mem_we;
                        idx_q   <= req_idx;
                        wdata_q <= mem_wdata;
                        oor_q   <= req_oor;
                        cnt_q   <= 8'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= (LATENCY == 1) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_cs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 8'd1) begin
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

            if (enter_ack) begin
                ack_q <= 1'b1;
                err_q <= cur_oor;
                if (!cur_we) begin
                    rdata_q <= cur_oor ? '0 : mem_q[cur_idx];
                end
            end else begin
                err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enter_ack && cur_we && !cur_oor) begin
            mem_q[cur_idx] <= cur_wdata;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ack   = ack_q;
    assign mem_busy  = busy_q;
    assign mem_err   = err_q;
endmodule

// File: tb/tb_l1_ext_mem_responder.sv
// Scoreboard bench for l1_ext_mem_responder: a LATENCY=10 instance under random traffic and a LATENCY=1 instance.
module tb_l1_ext_mem_responder;
    localparam int LAT0 = 10;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic         cs0, we0, ack0, busy0, err0;
    logic [31:0]  addr0;
    logic [127:0] wdata0, rdata0;
    logic         cs1, we1, ack1, busy1, err1;
    logic [31:0]  addr1;
    logic [127:0] wdata1, rdata1;

    l1_ext_mem_responder #(.ADDR_W(32), .BLOCK_W(128), .DEPTH(1024), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst(rst), .mem_cs(cs0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .mem_rdata(rdata0), .mem_ack(ack0), .mem_busy(busy0), .mem_err(err0));

    l1_ext_mem_responder #(.ADDR_W(32), .BLOCK_W(128), .DEPTH(1024), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst(rst), .mem_cs(cs1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .mem_rdata(rdata1), .mem_ack(ack1), .mem_busy(busy1), .mem_err(err1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         we;
        logic [127:0] rdata;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [127:0] ref0 [int];
    logic [127:0] ref1 [int];
    logic [127:0] last_rd [2];
    int           checks   = 0;
    int           failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int d, input logic c, input logic w, input logic [31:0] a,
                         input logic [127:0] wd);
        if (d == 0) begin cs0 = c; we0 = w; addr0 = a; wdata0 = wd; end
        else        begin cs1 = c; we1 = w; addr1 = a; wdata1 = wd; end
    endtask

    function automatic logic get_ack(input int d);
        return (d == 0) ? ack0 : ack1;
    endfunction

    // Monitor: every ack pops one expectation; between read acks mem_rdata must hold.
    task automatic mon(input int d, input logic ack, input logic busy, input logic err,
                       input logic [127:0] rd);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : q1.size();
        if (ack) begin
            if (n == 0) begin
                chk($sformatf("unexpected_ack%0d", d), ack, 1'b0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("ack_cycle%0d", d), cyc, e.cyc);
                chk($sformatf("ack_err%0d", d), err, e.err);
                chk($sformatf("ack_busy%0d", d), busy, 1'b1);
                if (!e.we) last_rd[d] = e.rdata;
                chk($sformatf("ack_rdata%0d", d), rd, last_rd[d]);
            end
        end else begin
            chk($sformatf("rdata_hold%0d", d), rd, last_rd[d]);
            chk($sformatf("err_idle%0d", d), err, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0, ack0, busy0, err0, rdata0);
            mon(1, ack1, busy1, err1, rdata1);
        end
    end

    function automatic logic out_of_range(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return a[31:14] != 18'd0;
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    // Issue one request at posedge+1; returns at posedge+1 of the IDLE cycle after ack with cs still high.
    task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [127:0] wd,
                          input bit scramble);
        exp_t e;
        int   idx;
        int   budget;
        logic oor;
        drive(d, 1'b1, w, a, wd);
        idx   = int'(a[13:4]);
        oor   = out_of_range(a);
        e.we  = w;
        e.err = oor;
        e.cyc = cyc + ((d == 0) ? LAT0 : LAT1);
        e.rdata = '0;
        if (w) begin
            if (!oor) begin
                if (d == 0) ref0[idx] = wd;
                else        ref1[idx] = wd;
            end
        end else if (!oor) begin
            e.rdata = (d == 0) ? ref0[idx] : ref1[idx];
        end
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
            if (scramble && budget == 2)
                drive(d, 1'b1, ~w, $urandom, {$urandom, $urandom, $urandom, $urandom});
        end while (!get_ack(d) && budget < 300);
        if (budget >= 300) chk("ack_timeout", get_ack(d), 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int d, input int n);
        if (d == 0) cs0 = 1'b0;
        else        cs1 = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Write that is abandoned in cycle 3 of its wait: no ack, no store update.
    task automatic abort_write(input logic [31:0] a, input logic [127:0] wd);
        drive(0, 1'b1, 1'b1, a, wd);
        repeat (3) begin @(posedge clk); #1; end
        cs0 = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy0, 1'b0);
        repeat (12) begin @(posedge clk); #1; end
    endtask

    int pool [8] = '{0, 1, 2, 4, 8, 16, 512, 1023};

    initial begin
        logic [127:0] d;
        logic [31:0]  a;
        logic [17:0]  hi;
        last_rd[0] = '0;
        last_rd[1] = '0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        repeat (5) @(negedge clk);
        chk("reset_ack", ack0, 1'b0);
        chk("reset_busy", busy0, 1'b0);
        chk("reset_rdata", rdata0, '0);
        chk("reset_ack1", ack1, 1'b0);
        @(posedge clk); #1;

        foreach (pool[i])
            do_req(0, 1'b1, 32'(pool[i]) << 4, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        idle(0, 2);

        do_req(0, 1'b1, 32'h40, {16{8'hA5}}, 1'b1);
        idle(0, 2);
        do_req(0, 1'b0, 32'h40, '0, 1'b1);
        idle(0, 2);

        // cs held across the ack; the read is re-sampled one cycle later
        do_req(0, 1'b1, 32'h80, {4{32'hC0DE_0080}}, 1'b0);
        do_req(0, 1'b0, 32'h80, '0, 1'b0);
        idle(0, 2);

        do_req(1, 1'b1, 32'h0, {4{32'h1111_2222}}, 1'b0);
        do_req(1, 1'b0, 32'h0, '0, 1'b0);
        idle(1, 1);
        do_req(1, 1'b1, 32'h10, {4{32'h3333_4444}}, 1'b0);
        do_req(1, 1'b0, 32'h10, '0, 1'b0);
        do_req(1, 1'b0, 32'h0, '0, 1'b0);
        idle(1, 2);

        abort_write(32'h40, {16{8'h5A}});
        do_req(0, 1'b0, 32'h40, '0, 1'b0);
        idle(0, 2);

        // asynchronous reset in the middle of a write to 0x100
        drive(0, 1'b1, 1'b1, 32'h100, {4{32'hDEAD_BEEF}});
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_ack", ack0, 1'b0);
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_rdata", rdata0, '0);
        chk("midrst_err", err0, 1'b0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        cs0 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        do_req(0, 1'b0, 32'h100, '0, 1'b0);
        idle(0, 1);

        do_req(0, 1'b0, 32'h0001_0000, '0, 1'b0);
        idle(0, 1);

        for (int i = 0; i < 40; i++) begin
            int unsigned r;
            r  = $urandom_range(0, 9);
            hi = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'd0;
            a  = {hi, 10'(pool[$urandom_range(0, 7)]), 4'($urandom)};
            d  = {$urandom, $urandom, $urandom, $urandom};
            if (r == 0) begin
                abort_write(a, d);
            end else begin
                do_req(0, r < 5, a, d, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) idle(0, $urandom_range(1, 3));
            end
        end
        idle(0, 20);
        idle(1, 1);

        chk("q0_drained", 128'(q0.size()), '0);
        chk("q1_drained", 128'(q1.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
